// File: rtl/jtag_uart_echo_master_if.sv
// Avalon-MM bundle between the echo master and the JTAG UART slave port.
// The master modport drives the request side; the slave modport answers with readdata/waitrequest.
interface jtag_uart_echo_master_if;
    logic        avm_chipselect;
    logic        avm_address;
    logic        avm_read_n;
    logic        avm_write_n;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    modport master (
        output avm_chipselect,
        output avm_address,
        output avm_read_n,
        output avm_write_n,
        output avm_writedata,
        input  avm_readdata,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_chipselect,
        input  avm_address,
        input  avm_read_n,
        input  avm_write_n,
        input  avm_writedata,
        output avm_readdata,
        output avm_waitrequest
    );
endinterface

// File: rtl/jtag_uart_echo_master.sv
// Avalon-MM master that polls the JTAG UART data register and writes each received byte back.
// Optional JU_ECHO_UPCASE_EN: lower-case ASCII is echoed as upper case (rx_byte stays raw).
//
// Handshake: a transfer is held (chipselect, strobe, address, writedata all registered and
// frozen) from the edge that asserts chipselect until the first rising edge that sees
// waitrequest=0; readdata is taken on that edge and the bus goes idle for at least one cycle.
module jtag_uart_echo_master #(
    parameter int POLL_CYCLES    = 1024,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 16
) (
    input  logic                    clk,
    input  logic                    reset_,
    jtag_uart_echo_master_if.master avm,
    output logic [7:0]              rx_byte,
    output logic                    rx_strobe,
    output logic [CNT_W-1:0]        echo_count,
    output logic                    timeout_err,
    output logic [1:0]              fsm_state
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RD_DATA = 2'd1;
    localparam logic [1:0] ST_RD_CTRL = 2'd2;
    localparam logic [1:0] ST_WR_DATA = 2'd3;

    localparam int POLL_W = $clog2(POLL_CYCLES + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [POLL_W-1:0] POLL_LOAD = POLL_W'(POLL_CYCLES);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]        state;
    logic [POLL_W-1:0] poll_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [15:0]       ravail;
    logic              cs_q;
    logic              addr_q;
    logic              rd_n_q;
    logic              wr_n_q;
    logic [31:0]       wdata_q;
    logic [7:0]        echo_byte;
    logic              unused_rd;

    assign avm.avm_chipselect = cs_q;
    assign avm.avm_address    = addr_q;
    assign avm.avm_read_n     = rd_n_q;
    assign avm.avm_write_n    = wr_n_q;
    assign avm.avm_writedata  = wdata_q;
    assign fsm_state          = state;
    assign unused_rd          = ^avm.avm_readdata[14:8];

`ifdef JU_ECHO_UPCASE_EN
    always_comb begin
        echo_byte = rx_byte;
        if (rx_byte >= 8'h61 && rx_byte <= 8'h7A) begin
            echo_byte = rx_byte - 8'h20;
        end
    end
`else
    assign echo_byte = rx_byte;
`endif

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state       <= ST_IDLE;
            poll_cnt    <= POLL_LOAD;
            to_cnt      <= '0;
            ravail      <= '0;
            cs_q        <= 1'b0;
            addr_q      <= 1'b0;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            wdata_q     <= '0;
            rx_byte     <= '0;
            rx_strobe   <= 1'b0;
            echo_count  <= '0;
            timeout_err <= 1'b0;
        end else begin
            rx_strobe <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (poll_cnt == '0) begin
                        state <= ST_RD_DATA;
                    end else begin
                        poll_cnt <= poll_cnt - POLL_W'(1);
                    end
                end
                default: begin
                    if (!cs_q) begin
                        // First cycle of a bus state is the idle gap; the request launches here.
                        cs_q   <= 1'b1;
                        addr_q <= (state == ST_RD_CTRL);
                        rd_n_q <= (state == ST_WR_DATA);
                        wr_n_q <= (state != ST_WR_DATA);
                        to_cnt <= '0;
                        if (state == ST_WR_DATA) begin
                            wdata_q <= {24'h0, echo_byte};
                        end
                    end else if (!avm.avm_waitrequest) begin
                        cs_q   <= 1'b0;
                        rd_n_q <= 1'b1;
                        wr_n_q <= 1'b1;
                        case (state)
                            ST_RD_DATA: begin
                                if (avm.avm_readdata[15]) begin
                                    rx_byte   <= avm.avm_readdata[7:0];
                                    rx_strobe <= 1'b1;
                                    ravail    <= avm.avm_readdata[31:16];
                                    state     <= ST_RD_CTRL;
                                end else begin
                                    poll_cnt <= POLL_LOAD;
                                    state    <= ST_IDLE;
                                end
                            end
                            ST_RD_CTRL: begin
                                // No write space: stay here and re-read, keeping the held byte.
                                if (avm.avm_readdata[31:16] != 16'h0) begin
                                    state <= ST_WR_DATA;
                                end
                            end
                            default: begin
                                echo_count <= echo_count + CNT_W'(1);
                                if (ravail != 16'h0) begin
                                    state <= ST_RD_DATA;
                                end else begin
                                    poll_cnt <= POLL_LOAD;
                                    state    <= ST_IDLE;
                                end
                            end
                        endcase
                    end else if (to_cnt == TO_LAST) begin
                        // Slave stalled too long: drop the transfer and any pending byte.
                        cs_q        <= 1'b0;
                        rd_n_q      <= 1'b1;
                        wr_n_q      <= 1'b1;
                        timeout_err <= 1'b1;
                        poll_cnt    <= POLL_LOAD;
                        state       <= ST_IDLE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_uart_echo_master.sv
// Directed bench for jtag_uart_echo_master: a negedge Avalon slave model with per-address
// stall lengths, a write scoreboard and immediate-assertion checks.
module tb_jtag_uart_echo_master;

    localparam int POLL = 8;
    localparam int TMO  = 255;

    logic        clk = 1'b0;
    logic        reset_ = 1'b0;
    logic [7:0]  rx_byte;
    logic        rx_strobe;
    logic [15:0] echo_count;
    logic        timeout_err;
    logic [1:0]  fsm_state;

    jtag_uart_echo_master_if bus ();

    jtag_uart_echo_master #(
        .POLL_CYCLES   (POLL),
        .TIMEOUT_CYCLES(TMO),
        .CNT_W         (16)
    ) dut (
        .clk        (clk),
        .reset_     (reset_),
        .avm        (bus),
        .rx_byte    (rx_byte),
        .rx_strobe  (rx_strobe),
        .echo_count (echo_count),
        .timeout_err(timeout_err),
        .fsm_state  (fsm_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_q[$];
    logic [31:0] wr_log[$];
    logic [31:0] data_q[$];
    logic [31:0] ctrl_q[$];
    int          gap_q[$];

    int cyc = 0, wr_count = 0, data_reads = 0, ctrl_reads = 0, strobes = 0;
    int stall_cycles = 0, stall_viol = 0, aborts = 0, abort_wait = 0, cur_wait = 0;
    int last_done = 0, lim = 0;
    int data_wait = 0, ctrl_wait = 0, wr_wait = 0;
    bit after_write = 1'b0, cs_prev = 1'b0;
    logic [7:0]  strobe_byte = 8'h0;
    logic [34:0] snap = '0;

    // Slave model and bus monitor; waitrequest/readdata change only on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (rx_strobe) begin
            strobes++;
            strobe_byte = rx_byte;
        end
        if (bus.avm_chipselect && !cs_prev && after_write) begin
            gap_q.push_back(cyc - last_done);
            after_write = 1'b0;
        end
        bus.avm_readdata = 32'hFFFF_7F00;
        if (bus.avm_chipselect) begin
            lim = bus.avm_address ? ctrl_wait : (!bus.avm_write_n ? wr_wait : data_wait);
            if (cur_wait > 0 && snap !== {bus.avm_address, bus.avm_read_n, bus.avm_write_n, bus.avm_writedata})
                stall_viol++;
            if (cur_wait < lim) begin
                if (cur_wait == 0)
                    snap = {bus.avm_address, bus.avm_read_n, bus.avm_write_n, bus.avm_writedata};
                bus.avm_waitrequest = 1'b1;
                cur_wait++;
                stall_cycles++;
            end else begin
                bus.avm_waitrequest = 1'b0;
                cur_wait = 0;
                if (!bus.avm_write_n) begin
                    wr_log.push_back(bus.avm_writedata);
                    wr_count++;
                    after_write = 1'b1;
                    last_done = cyc;
                end else if (!bus.avm_address) begin
                    bus.avm_readdata = (data_q.size() > 0) ? data_q.pop_front() : 32'h0000_0000;
                    data_reads++;
                end else begin
                    bus.avm_readdata = (ctrl_q.size() > 0) ? ctrl_q.pop_front() : 32'h0040_0000;
                    ctrl_reads++;
                end
            end
        end else begin
            if (cur_wait != 0) begin
                aborts++;
                abort_wait = cur_wait;
            end
            bus.avm_waitrequest = 1'b0;
            cur_wait = 0;
        end
        cs_prev = bus.avm_chipselect;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_writes(input int n, input string tag);
        int i = 0;
        while (wr_count < n && i < 3000) begin
            @(negedge clk);
            i++;
        end
        check(tag, 32'(wr_count >= n), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_gaps(input int n, input string tag);
        int i = 0;
        while (gap_q.size() < n && i < 3000) begin
            @(negedge clk);
            i++;
        end
        check(tag, 32'(gap_q.size() >= n), 32'd1);
    endtask

    task automatic sb_drain(input string tag);
        logic [31:0] obs;
        while (exp_q.size() > 0) begin
            obs = (wr_log.size() > 0) ? wr_log.pop_front() : 32'hDEAD_DEAD;
            check(tag, obs, exp_q.pop_front());
        end
        check({tag, "_extra"}, 32'(wr_log.size()), 32'd0);
    endtask

    int base_ctrl, base_wr, base_str, base_abort, i;

    initial begin
        bus.avm_waitrequest = 1'b0;
        bus.avm_readdata    = 32'h0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cs", 32'(bus.avm_chipselect), 32'd0);
        check("rst_rd_n", 32'(bus.avm_read_n), 32'd1);
        check("rst_wr_n", 32'(bus.avm_write_n), 32'd1);
        check("rst_addr", 32'(bus.avm_address), 32'd0);
        check("rst_wdata", bus.avm_writedata, 32'd0);
        check("rst_rx_byte", 32'(rx_byte), 32'd0);
        check("rst_rx_strobe", 32'(rx_strobe), 32'd0);
        check("rst_echo_count", 32'(echo_count), 32'd0);
        check("rst_timeout", 32'(timeout_err), 32'd0);

        // Single character
        data_q.push_back(32'h0000_8041);
        ctrl_q.push_back(32'h0040_0000);
        exp_q.push_back(32'h0000_0041);
        reset_ = 1'b1;
        wait_writes(1, "single_wait");
        check("single_echo_count", 32'(echo_count), 32'd1);
        check("single_strobes", 32'(strobes), 32'd1);
        check("single_strobe_byte", 32'(strobe_byte), 32'h41);
        check("single_rx_byte", 32'(rx_byte), 32'h41);
        check("single_ctrl_reads", 32'(ctrl_reads), 32'd1);
        sb_drain("single_sb");
        wait_gaps(1, "single_gap_wait");
        check("single_poll_gap", 32'(gap_q[0] >= POLL + 1), 32'd1);

        // Burst of three queued characters
        gap_q.delete();
        base_ctrl = ctrl_reads;
        base_str  = strobes;
        data_q.push_back(32'h0002_8061);
        data_q.push_back(32'h0001_8062);
        data_q.push_back(32'h0000_8063);
`ifdef JU_ECHO_UPCASE_EN
        exp_q.push_back(32'h41); exp_q.push_back(32'h42); exp_q.push_back(32'h43);
`else
        exp_q.push_back(32'h61); exp_q.push_back(32'h62); exp_q.push_back(32'h63);
`endif
        wait_writes(4, "burst_wait");
        check("burst_echo_count", 32'(echo_count), 32'd4);
        check("burst_ctrl_reads", 32'(ctrl_reads - base_ctrl), 32'd3);
        check("burst_strobes", 32'(strobes - base_str), 32'd3);
        check("burst_last_byte", 32'(strobe_byte), 32'h63);
        sb_drain("burst_sb");
        wait_gaps(3, "burst_gap_wait");
        check("burst_gap0", 32'(gap_q[0]), 32'd2);
        check("burst_gap1", 32'(gap_q[1]), 32'd2);
        check("burst_gap2_poll", 32'(gap_q[2] >= POLL + 1), 32'd1);

        // Back-pressure: no write space four times
        base_ctrl = ctrl_reads;
        base_wr   = wr_count;
        for (int k = 0; k < 4; k++) ctrl_q.push_back(32'h0000_0000);
        ctrl_q.push_back(32'h0001_0000);
        data_q.push_back(32'h0000_8042);
        exp_q.push_back(32'h42);
        wait_writes(base_wr + 1, "bp_wait");
        check("bp_ctrl_reads", 32'(ctrl_reads - base_ctrl), 32'd5);
        check("bp_writes", 32'(wr_count - base_wr), 32'd1);
        check("bp_echo_count", 32'(echo_count), 32'd5);
        sb_drain("bp_sb");

        // Waitrequest held 10 cycles on every transfer
        stall_viol = 0;
        stall_cycles = 0;
        data_wait = 10; ctrl_wait = 10; wr_wait = 10;
        data_q.push_back(32'h0000_8043);
        exp_q.push_back(32'h43);
        wait_writes(wr_count + 1, "wait10_wait");
        check("wait10_stable", 32'(stall_viol), 32'd0);
        check("wait10_stalled", 32'(stall_cycles >= 30), 32'd1);
        check("wait10_echo_count", 32'(echo_count), 32'd6);
        sb_drain("wait10_sb");
        data_wait = 0; ctrl_wait = 0; wr_wait = 0;

        // Waitrequest held 300 cycles on the control read -> timeout
        base_ctrl  = ctrl_reads;
        base_wr    = wr_count;
        base_abort = aborts;
        ctrl_wait  = 300;
        data_q.push_back(32'h0000_8044);
        i = 0;
        while (!timeout_err && i < 1500) begin
            @(negedge clk);
            i++;
        end
        ctrl_wait = 0;
        check("tmo_flag", 32'(timeout_err), 32'd1);
        @(negedge clk);
        check("tmo_cs_released", 32'(bus.avm_chipselect), 32'd0);
        check("tmo_aborts", 32'(aborts - base_abort), 32'd1);
        check("tmo_stall_len", 32'(abort_wait), 32'd255);
        check("tmo_rx_byte", 32'(rx_byte), 32'h44);
        repeat (3 * POLL + 10) @(negedge clk);
        check("tmo_no_write", 32'(wr_count - base_wr), 32'd0);
        check("tmo_no_ctrl_done", 32'(ctrl_reads - base_ctrl), 32'd0);
        check("tmo_echo_count", 32'(echo_count), 32'd6);
        check("tmo_sticky", 32'(timeout_err), 32'd1);
        sb_drain("tmo_sb");

        // Asynchronous reset during a stalled write
        wr_wait = 40;
        data_q.push_back(32'h0000_8045);
        i = 0;
        while (bus.avm_write_n !== 1'b0 && i < 500) begin
            @(negedge clk);
            i++;
        end
        check("rstw_write_seen", 32'(bus.avm_write_n), 32'd0);
        #2 reset_ = 1'b0;
        #1;
        check("rstw_wr_n", 32'(bus.avm_write_n), 32'd1);
        check("rstw_cs", 32'(bus.avm_chipselect), 32'd0);
        check("rstw_rd_n", 32'(bus.avm_read_n), 32'd1);
        check("rstw_addr", 32'(bus.avm_address), 32'd0);
        check("rstw_wdata", bus.avm_writedata, 32'd0);
        check("rstw_rx_byte", 32'(rx_byte), 32'd0);
        check("rstw_echo_count", 32'(echo_count), 32'd0);
        check("rstw_timeout", 32'(timeout_err), 32'd0);
        repeat (2) @(negedge clk);
        wr_wait = 0;
        wr_log.delete();
        reset_ = 1'b1;

        // Recovery after reset
        data_q.push_back(32'h0000_8046);
        exp_q.push_back(32'h46);
        wait_writes(wr_count + 1, "recover_wait");
        check("recover_echo_count", 32'(echo_count), 32'd1);
        sb_drain("recover_sb");

`ifdef JU_ECHO_UPCASE_EN
        data_q.push_back(32'h0001_807A);
        data_q.push_back(32'h0000_8031);
        exp_q.push_back(32'h5A);
        exp_q.push_back(32'h31);
        wait_writes(wr_count + 2, "upcase_wait");
        check("upcase_raw_rx", 32'(rx_byte), 32'h31);
        sb_drain("upcase_sb");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
